// File: rtl/crg_pkg.sv
// Shared types and helpers for the CRG clock-enable / reset sequencer.
// Holds the per-channel state enum and the channel counter width.
package crg_pkg;

    typedef enum logic [2:0] {
        OFF,
        SETTLE,
        HOLD,
        RUN,
        DRAIN
    } crg_ch_state_e;

    function automatic int crg_cnt_w(input int g, input int r);
        return $clog2(((g > r) ? g : r) + 1);
    endfunction

endpackage

// File: rtl/crg_ch_fsm.sv
// One output-clock channel: gate off, switch mux, settle, gate on,
// hold reset, release. Drops to OFF whenever lock_ok is low.
module crg_ch_fsm
    import crg_pkg::*;
#(
    parameter int GATE_CYC = 8,
    parameter int RST_HOLD = 16
)(
    input  logic clk,
    input  logic rst,
    input  logic lock_ok,
    input  logic req_en,
    input  logic req_sel,
    output logic clk_en,
    output logic clk_sel,
    output logic rst_out,
    output logic ch_ready
);

    localparam int CW = crg_cnt_w(GATE_CYC, RST_HOLD);
    localparam logic [CW-1:0] G_LD = CW'(GATE_CYC - 1);
    localparam logic [CW-1:0] R_LD = CW'(RST_HOLD - 1);

    crg_ch_state_e   state;
    logic [CW-1:0]   cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= OFF;
            cnt      <= '0;
            clk_en   <= 1'b0;
            clk_sel  <= 1'b0;
            rst_out  <= 1'b1;
            ch_ready <= 1'b0;
        end else if (!lock_ok) begin
            state    <= OFF;
            cnt      <= '0;
            clk_en   <= 1'b0;
            rst_out  <= 1'b1;
            ch_ready <= 1'b0;
        end else begin
            unique case (state)
                OFF: begin
                    // mux select only moves here, with the gate closed
                    if (req_en) begin
                        state   <= SETTLE;
                        cnt     <= G_LD;
                        clk_sel <= req_sel;
                    end
                end
                SETTLE: begin
                    if (!req_en) begin
                        state <= OFF;
                    end else if (cnt == '0) begin
                        state  <= HOLD;
                        cnt    <= R_LD;
                        clk_en <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                HOLD: begin
                    if (!req_en) begin
                        state <= DRAIN;
                        cnt   <= G_LD;
                    end else if (cnt == '0) begin
                        state    <= RUN;
                        rst_out  <= 1'b0;
                        ch_ready <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RUN: begin
                    if (!req_en || (req_sel != clk_sel)) begin
                        state    <= DRAIN;
                        cnt      <= G_LD;
                        rst_out  <= 1'b1;
                        ch_ready <= 1'b0;
                    end
                end
                DRAIN: begin
                    // clock keeps running so downstream flops see reset
                    if (cnt == '0) begin
                        state  <= OFF;
                        clk_en <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state    <= OFF;
                    cnt      <= '0;
                    clk_en   <= 1'b0;
                    rst_out  <= 1'b1;
                    ch_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/crg_seq_ctrl.sv
// CRG clock-enable and reset sequencer: lock filter plus NUM_CLK channels.
// Define CRG_SEQ_LOSS_CNT_EN to add the saturating lock_loss_cnt output.
module crg_seq_ctrl
    import crg_pkg::*;
#(
    parameter int NUM_CLK   = 4,
    parameter int GATE_CYC  = 8,
    parameter int RST_HOLD  = 16,
    parameter int LOCK_FILT = 32
)(
    input  logic               clk_src,
    input  logic               rst_sys,
    input  logic               pll_locked,
    input  logic [NUM_CLK-1:0] req_en,
    input  logic [NUM_CLK-1:0] req_sel,
    output logic [NUM_CLK-1:0] clk_en,
    output logic [NUM_CLK-1:0] clk_sel,
    output logic [NUM_CLK-1:0] rst_out,
    output logic [NUM_CLK-1:0] ch_ready,
    output logic               all_ready,
`ifdef CRG_SEQ_LOSS_CNT_EN
    output logic [7:0]         lock_loss_cnt,
`endif
    output logic               lock_ok
);

    localparam int FW = $clog2(LOCK_FILT + 1);

    logic          lk_s1;
    logic          lk_s;
    logic [FW-1:0] filt_cnt;

    always_ff @(posedge clk_src or posedge rst_sys) begin
        if (rst_sys) begin
            lk_s1     <= 1'b0;
            lk_s      <= 1'b0;
            filt_cnt  <= '0;
            lock_ok   <= 1'b0;
            all_ready <= 1'b0;
        end else begin
            lk_s1     <= pll_locked;
            lk_s      <= lk_s1;
            all_ready <= &ch_ready;
            if (!lk_s) begin
                filt_cnt <= '0;
                lock_ok  <= 1'b0;
            end else if (!lock_ok) begin
                if (filt_cnt == FW'(LOCK_FILT - 1))
                    lock_ok <= 1'b1;
                else
                    filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

`ifdef CRG_SEQ_LOSS_CNT_EN
    // lock_ok falls exactly when it is high and lk_s is low
    always_ff @(posedge clk_src or posedge rst_sys) begin
        if (rst_sys)
            lock_loss_cnt <= 8'd0;
        else if (lock_ok && !lk_s && (lock_loss_cnt != 8'hFF))
            lock_loss_cnt <= lock_loss_cnt + 8'd1;
    end
`endif

    for (genvar i = 0; i < NUM_CLK; i++) begin : g_ch
        crg_ch_fsm #(
            .GATE_CYC (GATE_CYC),
            .RST_HOLD (RST_HOLD)
        ) u_ch (
            .clk      (clk_src),
            .rst      (rst_sys),
            .lock_ok  (lock_ok),
            .req_en   (req_en[i]),
            .req_sel  (req_sel[i]),
            .clk_en   (clk_en[i]),
            .clk_sel  (clk_sel[i]),
            .rst_out  (rst_out[i]),
            .ch_ready (ch_ready[i])
        );
    end

endmodule
